aes_frame_ctrl: RTL

- Framed command controller between the UART byte stream and the AES core. It is the parametrised successor to the fixed 128-bit plaintext-in/ciphertext-out path.
- Receives a command byte followed by BLOCK_BYTES payload bytes.
- Supports key loading as well as encryption, plus inter-byte timeout and error reporting.
- Serialises the response (ciphertext, ACK or NAK) back to the UART transmitter.

---
 rtl/aes_link_pkg.sv | 13 +
 rtl/frame_timeout_ctr.sv | 21 ++
 rtl/aes_frame_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/aes_link_pkg.sv
// aes_link_pkg: shared FSM states, command/response byte defaults and counter-width helpers
package aes_link_pkg;
  typedef enum logic [2:0] {IDLE, RX_PAY, EXEC, AES_WAIT, TX_SEND, TX_WAIT} state_e;
  localparam logic [7:0] CMD_KEY_DEF = 8'h01;
  localparam logic [7:0] CMD_ENC_DEF = 8'h02;
  localparam logic [7:0] ACK_DEF = 8'hA5;
  localparam logic [7:0] NAK_DEF = 8'hEE;
  localparam int BLOCK_BYTES_DEF = 16;
  localparam int CNT_W = $clog2(BLOCK_BYTES_DEF + 1);
  function automatic int cnt_w(int bb);
    return $clog2(bb + 1);
  endfunction
endpackage

// File: rtl/frame_timeout_ctr.sv
// frame_timeout_ctr: reloadable down-counter that pulses expire when an enabled wait runs out
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic expire
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = restart ? W'(TIMEOUT_CYCLES - 1) : (en && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  end
  // a zero timeout disables expiry entirely; a same-cycle restart always wins
  assign expire = (TIMEOUT_CYCLES != 0) && en && !restart && cnt_q == '0;
  always_ff @(posedge clk) begin
    cnt_q <= reset ? '0 : cnt_d;
  end
endmodule

// File: rtl/aes_frame_ctrl.sv
// aes_frame_ctrl: framed UART command controller feeding the AES core (key load / encrypt)
module aes_frame_ctrl
  import aes_link_pkg::*;
#(
  parameter int BLOCK_BYTES = BLOCK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] CMD_KEY = CMD_KEY_DEF,
  parameter logic [7:0] CMD_ENC = CMD_ENC_DEF,
  parameter logic [7:0] ACK_BYTE = ACK_DEF,
  parameter logic [7:0] NAK_BYTE = NAK_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_done,
  input  logic                     aes_ready,
  output logic                     aes_start,
  output logic                     aes_key_load,
  output logic [8*BLOCK_BYTES-1:0] pt_to_aes,
  output logic [8*BLOCK_BYTES-1:0] key_to_aes,
  input  logic [8*BLOCK_BYTES-1:0] ct_from_aes,
  output logic                     busy,
  output logic                     err_timeout,
  output logic                     err_overrun
);
  localparam int BW = 8 * BLOCK_BYTES;
  localparam int CW = cnt_w(BLOCK_BYTES);
  state_e state_q, state_d;
  logic key_cmd_q, key_cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] pay_q, pay_d, tx_q, tx_d, key_q, key_d, pt_q, pt_d, pay_shift;
  logic aes_start_q, aes_start_d, key_load_q, key_load_d, tx_start_q, tx_start_d;
  logic err_to_q, err_to_d, err_ov_q, err_ov_d, expire;
  assign pay_shift = BW'({pay_q, rx_data});
  frame_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk, .reset, .en(state_q == RX_PAY), .restart(rx_valid), .expire
  );
  always_comb begin
    state_d = state_q;
    key_cmd_d = key_cmd_q;
    cnt_d = cnt_q;
    pay_d = pay_q;
    tx_d = tx_q;
    key_d = key_q;
    pt_d = pt_q;
    aes_start_d = 1'b0;
    key_load_d = 1'b0;
    tx_start_d = 1'b0;
    err_to_d = 1'b0;
    err_ov_d = rx_valid && !err_ov_q && state_q != IDLE && state_q != RX_PAY;
    case (state_q)
      IDLE: if (rx_valid) begin
        if (rx_data == CMD_KEY || rx_data == CMD_ENC) begin
          key_cmd_d = rx_data == CMD_KEY;
          cnt_d = '0;
          state_d = RX_PAY;
        end else begin
          tx_d = BW'(NAK_BYTE) << (BW - 8);
          cnt_d = CW'(1);
          state_d = TX_SEND;
        end
      end
      RX_PAY: if (rx_valid) begin
        pay_d = pay_shift;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BLOCK_BYTES - 1)) begin
          state_d = EXEC;
          pt_d = key_cmd_q ? pt_q : pay_shift;
        end
      end else if (expire) begin
        err_to_d = 1'b1;
        state_d = IDLE;
      end
      EXEC: if (aes_ready) begin
        if (key_cmd_q) begin
          key_d = pay_q;
          key_load_d = 1'b1;
          tx_d = BW'(ACK_BYTE) << (BW - 8);
          cnt_d = CW'(1);
          state_d = TX_SEND;
        end else begin
          aes_start_d = 1'b1;
          state_d = AES_WAIT;
        end
      end
      // aes_start_q marks the first AES_WAIT cycle, where a stale ready is ignored
      AES_WAIT: if (aes_ready && !aes_start_q) begin
        tx_d = ct_from_aes;
        cnt_d = CW'(BLOCK_BYTES);
        state_d = TX_SEND;
      end
      TX_SEND: begin
        tx_start_d = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: if (tx_done) begin
        tx_d = tx_q << 8;
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? IDLE : TX_SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_cmd_q <= 1'b0;
      cnt_q <= '0;
      pay_q <= '0;
      tx_q <= '0;
      key_q <= '0;
      pt_q <= '0;
      aes_start_q <= 1'b0;
      key_load_q <= 1'b0;
      tx_start_q <= 1'b0;
      err_to_q <= 1'b0;
      err_ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_cmd_q <= key_cmd_d;
      cnt_q <= cnt_d;
      pay_q <= pay_d;
      tx_q <= tx_d;
      key_q <= key_d;
      pt_q <= pt_d;
      aes_start_q <= aes_start_d;
      key_load_q <= key_load_d;
      tx_start_q <= tx_start_d;
      err_to_q <= err_to_d;
      err_ov_q <= err_ov_d;
    end
  end
  assign tx_data = tx_q[BW-1 -: 8];
  assign tx_start = tx_start_q;
  assign aes_start = aes_start_q;
  assign aes_key_load = key_load_q;
  assign pt_to_aes = pt_q;
  assign key_to_aes = key_q;
  assign busy = state_q != IDLE;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;
endmodule
